uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 14 +
 rtl/uart_rx_fifo_rx_fifo.sv | 65 ++++++
 rtl/uart_rx_fifo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receiver and its receive buffer.
package uart_rx_fifo_pkg;

  localparam int unsigned FifoDepth = 4;
  localparam int unsigned DataWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_rx_fifo.sv
// First-word-fall-through receive buffer with wrap-around pointers and an occupancy count.
// A push into a full buffer is dropped unless a pop frees the head in the same cycle.
module rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned Depth = FifoDepth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  output logic                 overflow_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 empty, full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty;
  // A simultaneous pop makes room, so a full buffer still accepts the push.
  assign do_push = push_i && (!full || do_pop);

  assign overflow_o = push_i && !do_push;
  assign valid_o    = !empty;
  assign data_o     = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a receive buffer with sticky overrun / framing-error flags.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [DataWidth-1:0] rd_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CntW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW         = $clog2(DataWidth);
  localparam logic [CntW-1:0] HalfCnt  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_FIFO_EN
  localparam int unsigned BufDepth = FifoDepth;
`else
  localparam int unsigned BufDepth = 1;
`endif

  logic [1:0]           sync_q;
  logic                 rxd_s;
  rx_state_e            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic [DataWidth-1:0] shift_q;
  logic                 stop_tick, push, frame_evt, fifo_overflow;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd};
  end

  assign rxd_s = sync_q[1];

  // Stop-bit sample cycle: the byte is pushed (or rejected) at the end of this cycle.
  assign stop_tick = (state_q == StStop) && (cnt_q == FullCnt);
  assign push      = stop_tick && rxd_s;
  assign frame_evt = stop_tick && !rxd_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!rxd_s) state_q <= StStart;
        end
        StStart: begin
          if (cnt_q == HalfCnt) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxd_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == FullCnt) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[DataWidth-1:1]};
            if (bit_idx_q == IdxW'(DataWidth - 1)) state_q <= StStop;
            else bit_idx_q <= bit_idx_q + IdxW'(1);
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == FullCnt) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A set event takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (fifo_overflow) overrun <= 1'b1;
      else if (err_clr)  overrun <= 1'b0;
      if (frame_evt)     frame_err <= 1'b1;
      else if (err_clr)  frame_err <= 1'b0;
    end
  end

  rx_fifo #(
    .Depth(BufDepth)
  ) u_rx_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .push_i    (push),
    .data_i    (shift_q),
    .pop_i     (rd_en),
    .data_o    (rd_data),
    .valid_o   (rx_valid),
    .overflow_o(fifo_overflow)
  );

endmodule
